// File: rtl/bbox_engine.sv
// Screen-space bounding box of one primitive: min/max over NUM_VERT fixed-point
// vertices, rounded half-up to integer pixels, clamped to the screen, culled if off-screen.
module bbox_engine #(
  parameter int COORD_W  = 16,
  parameter int FRAC_W   = 6,
  parameter int NUM_VERT = 3,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  localparam int INT_W   = COORD_W - FRAC_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INT_W-1:0]   xmin,
  output logic [INT_W-1:0]   xmax,
  output logic [INT_W-1:0]   ymin,
  output logic [INT_W-1:0]   ymax,
  output logic               culled,
  output logic [7:0]         prim_id
);

  localparam int CNT_W = (NUM_VERT > 1) ? $clog2(NUM_VERT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VERT - 1);
  localparam logic [INT_W-1:0] XLIM = INT_W'(SCREEN_W - 1);
  localparam logic [INT_W-1:0] YLIM = INT_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {COLLECT, ROUND, HOLD} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] xlo_q, xhi_q, ylo_q, yhi_q;
  logic [COORD_W-1:0] xlo_d, xhi_d, ylo_d, yhi_d;
  logic [INT_W-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
  logic [INT_W-1:0]   xmin_d, xmax_d, ymin_d, ymax_d;
  logic [INT_W-1:0]   rxlo, rxhi, rylo, ryhi;
  logic               culled_q, culled_d, out_valid_q;
  logic [7:0]         prim_id_q;

  // Half-up rounding at INT_W+1 bits; a carry out saturates to the top pixel code.
  function automatic logic [INT_W-1:0] rnd(input logic [COORD_W-1:0] v);
    logic [INT_W:0] r;
    r = {1'b0, v[COORD_W-1:FRAC_W]} + {{INT_W{1'b0}}, v[FRAC_W-1]};
    return r[INT_W] ? {INT_W{1'b1}} : r[INT_W-1:0];
  endfunction

  function automatic logic [INT_W-1:0] clamp(input logic [INT_W-1:0] v,
                                             input logic [INT_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  always_comb begin
    xlo_d = xlo_q;
    xhi_d = xhi_q;
    ylo_d = ylo_q;
    yhi_d = yhi_q;
    // First vertex seeds all accumulators; ties keep the stored value.
    if (cnt_q == '0 || in_x < xlo_q) xlo_d = in_x;
    if (cnt_q == '0 || in_x > xhi_q) xhi_d = in_x;
    if (cnt_q == '0 || in_y < ylo_q) ylo_d = in_y;
    if (cnt_q == '0 || in_y > yhi_q) yhi_d = in_y;
  end

  always_comb begin
    rxlo     = rnd(xlo_q);
    rxhi     = rnd(xhi_q);
    rylo     = rnd(ylo_q);
    ryhi     = rnd(yhi_q);
    xmin_d   = clamp(rxlo, XLIM);
    xmax_d   = clamp(rxhi, XLIM);
    ymin_d   = clamp(rylo, YLIM);
    ymax_d   = clamp(ryhi, YLIM);
    culled_d = (rxlo > XLIM) || (rylo > YLIM);
  end

  // HOLD spends one cycle settling before raising out_valid, giving a
  // two-edge latency from the last vertex accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      xlo_q       <= '0;
      xhi_q       <= '0;
      ylo_q       <= '0;
      yhi_q       <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      culled_q    <= 1'b0;
      out_valid_q <= 1'b0;
      prim_id_q   <= '0;
    end else if (clear) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: if (in_valid) begin
          xlo_q <= xlo_d;
          xhi_q <= xhi_d;
          ylo_q <= ylo_d;
          yhi_q <= yhi_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= ROUND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ROUND: begin
          xmin_q   <= xmin_d;
          xmax_q   <= xmax_d;
          ymin_q   <= ymin_d;
          ymax_q   <= ymax_d;
          culled_q <= culled_d;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= COLLECT;
            prim_id_q   <= prim_id_q + 8'd1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = out_valid_q;
  assign xmin      = xmin_q;
  assign xmax      = xmax_q;
  assign ymin      = ymin_q;
  assign ymax      = ymax_q;
  assign culled    = culled_q;
  assign prim_id   = prim_id_q;

endmodule

// File: tb/tb_bbox_engine.sv
// Directed bench for bbox_engine: expected boxes are queued at issue time and
// a negedge monitor compares them against each accepted result.
module tb_bbox_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        in_ready, out_valid, culled;
  logic [9:0]  xmin, xmax, ymin, ymax;
  logic [7:0]  prim_id;

  bbox_engine dut (
    .CLK(CLK), .RST(RST), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .culled(culled), .prim_id(prim_id)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0] xmin, xmax, ymin, ymax;
    logic       culled;
    logic [7:0] id;
  } res_t;

  res_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_id = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_box(input logic [9:0] x0, x1, y0, y1, input logic c);
    res_t e;
    e = '{xmin: x0, xmax: x1, ymin: y0, ymax: y1, culled: c, id: exp_id};
    sb.push_back(e);
    exp_id++;
  endtask

  always @(negedge CLK) begin
    res_t e;
    if (!RST && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got prim_id %0d expected no result", prim_id);
      end else begin
        e = sb.pop_front();
        chk("res_xmin", xmin, e.xmin);
        chk("res_xmax", xmax, e.xmax);
        chk("res_ymin", ymin, e.ymin);
        chk("res_ymax", ymax, e.ymax);
        chk("res_culled", culled, e.culled);
        chk("res_prim_id", prim_id, e.id);
      end
    end
  end

  task automatic send_vtx(input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    @(negedge CLK);
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_prim(input logic [15:0] x0, x1, x2, y0, y1, y2);
    send_vtx(x0, y0);
    send_vtx(x1, y1);
    send_vtx(x2, y2);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge CLK);
    while (!out_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!out_valid) chk("valid_timeout", out_valid, 1);
  endtask

  initial begin
    int n;
    #1 RST = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xmin", xmin, 0);
    chk("rst_ymax", ymax, 0);
    chk("rst_culled", culled, 0);
    chk("rst_prim_id", prim_id, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", in_ready, 1);
    @(posedge CLK); #1;

    // Basic box with two-edge latency
    expect_box(41, 639, 5, 21, 0);
    send_prim(16'h0A20, 16'h1910, 16'hAF00, 16'h0280, 16'h0530, 16'h0140);
    @(negedge CLK);
    chk("lat_round_valid", out_valid, 0);
    chk("round_in_ready", in_ready, 0);
    @(negedge CLK);
    chk("lat_k1_valid", out_valid, 0);
    @(negedge CLK);
    chk("lat_k2_valid", out_valid, 1);
    @(posedge CLK); #1;

    // Entirely right of screen
    expect_box(639, 639, 1, 3, 1);
    send_prim(16'hA280, 16'hA500, 16'hAF00, 16'h0040, 16'h0080, 16'h00C0);
    wait_valid();
    @(posedge CLK); #1;

    // Backpressure: hold for 5 cycles
    out_ready = 1'b0;
    expect_box(1, 3, 1, 3, 0);
    send_prim(16'h0040, 16'h0080, 16'h00C0, 16'h0040, 16'h0080, 16'h00C0);
    wait_valid();
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_xmax", xmax, 3);
      chk("stall_prim_id", prim_id, 2);
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_prim_id", prim_id, 3);
    chk("post_hs_xmax_hold", xmax, 3);

    // Clear after two vertices; the vertex presented on the clear edge is dropped
    send_vtx(16'h1000, 16'h1000);
    send_vtx(16'h2000, 16'h0010);
    clear = 1'b1;
    in_valid = 1'b1;
    in_x = 16'h0000;
    in_y = 16'h0000;
    @(posedge CLK); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    expect_box(1, 3, 1, 3, 0);
    send_prim(16'h0040, 16'h0080, 16'h00C0, 16'h0040, 16'h0080, 16'h00C0);
    wait_valid();
    @(posedge CLK); #1;

    // Clear while holding a result: result discarded, prim_id unchanged
    out_ready = 1'b0;
    expect_box(2, 2, 2, 2, 0);
    send_prim(16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0080);
    wait_valid();
    @(posedge CLK); #1;
    clear = 1'b1;
    @(posedge CLK); #1;
    clear = 1'b0;
    void'(sb.pop_back());
    exp_id--;
    chk("clr_hold_valid", out_valid, 0);
    chk("clr_hold_prim_id", prim_id, 4);
    chk("clr_hold_in_ready", in_ready, 1);
    chk("clr_hold_xmin_hold", xmin, 2);
    out_ready = 1'b1;

    // Saturating round then clamp
    expect_box(1, 639, 1, 3, 0);
    send_prim(16'hFFFF, 16'h0040, 16'h0080, 16'h0040, 16'h0080, 16'h00C0);
    wait_valid();
    @(posedge CLK); #1;

    // Entirely below screen
    expect_box(1, 3, 479, 479, 1);
    send_prim(16'h0040, 16'h0080, 16'h00C0, 16'h7800, 16'h7900, 16'h7A00);
    wait_valid();
    @(posedge CLK); #1;

    // Reset while holding: everything zero at once, no result emitted
    out_ready = 1'b0;
    expect_box(1, 639, 1, 3, 0);
    send_prim(16'hFFFF, 16'h0040, 16'h0080, 16'h0040, 16'h0080, 16'h00C0);
    wait_valid();
    chk("pre_rst_xmax", xmax, 639);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("hold_rst_valid", out_valid, 0);
    chk("hold_rst_xmax", xmax, 0);
    chk("hold_rst_ymax", ymax, 0);
    chk("hold_rst_prim_id", prim_id, 0);
    void'(sb.pop_back());
    exp_id = 8'd0;
    @(posedge CLK); #1;
    RST = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge CLK); #1;

    // 257 back-to-back primitives: prim_id wraps 255 -> 0 -> 1
    for (int i = 0; i < 257; i++) begin
      expect_box(4, 4, 4, 4, 0);
      send_prim(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge CLK); #1;
    chk("wrap_prim_id", prim_id, 1);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bbox_engine.md
BBOX_ENGINE -- requirements
Module: bbox_engine

Interface
REQ-001 Parameter: COORD_W, 16, total unsigned fixed-point coordinate width.
REQ-002 Parameter: FRAC_W, 6, fractional bits; INT_W = COORD_W-FRAC_W; 1 <= FRAC_W < COORD_W.
REQ-003 Parameter: NUM_VERT, 3, vertices per primitive; NUM_VERT >= 1.
REQ-004 Parameter: SCREEN_W, 640, screen width in pixels; 1 <= SCREEN_W <= 2^INT_W.
REQ-005 Parameter: SCREEN_H, 480, screen height in pixels; 1 <= SCREEN_H <= 2^INT_W.
REQ-006 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-007 Port: RST  input  1  asynchronous, active-high reset.
REQ-008 Port: clear  input  1  synchronous abort of the current primitive.
REQ-009 Port: in_valid  input  1  vertex present on in_x/in_y.
REQ-010 Port: in_ready  output  1  block accepts a vertex this cycle.
REQ-011 Port: in_x, in_y  input  COORD_W each  unsigned vertex coordinates.
REQ-012 Port: out_valid  output  1  bounding box result valid.
REQ-013 Port: out_ready  input  1  downstream accepts result.
REQ-014 Port: xmin, xmax, ymin, ymax  output  INT_W each  rounded, clamped integer pixel bounds.
REQ-015 Port: culled  output  1  box lies entirely off-screen.
REQ-016 Port: prim_id  output  8  sequence number of the current result.

Function
REQ-017 FSM states: COLLECT, ROUND, HOLD; a vertex is accepted on an edge where in_valid && in_ready.
REQ-018 in_ready = 1 only in COLLECT; out_valid = 1 only in HOLD.
REQ-019 COLLECT: first accepted vertex (count 0) loads all four min/max accumulators directly; later vertices update them with unsigned compares (ties keep the stored value).
REQ-020 COLLECT: vertex counter increments per accept; accepting vertex NUM_VERT-1 moves to ROUND and resets the counter to 0.
REQ-021 ROUND (exactly one cycle): each bound is rounded half-up, r = (v >> FRAC_W) + v[FRAC_W-1], computed at INT_W+1 bits, saturated to 2^INT_W-1.
REQ-022 ROUND: x bounds are clamped to SCREEN_W-1 and y bounds to SCREEN_H-1; the results are registered into the outputs on the edge leaving ROUND; state goes to HOLD.
REQ-023 culled = 1 when rounded xmin > SCREEN_W-1 or rounded ymin > SCREEN_H-1 (evaluated before clamping); registered with the bounds.
REQ-024 Latency: last vertex accepted at edge k gives out_valid = 1 after edge k+2.
REQ-025 HOLD: outputs and out_valid remain stable until out_ready = 1; the accepting edge returns to COLLECT, clears out_valid, and increments prim_id (wraps 255 -> 0).
REQ-026 No overlap: no vertex is accepted in ROUND or HOLD; the next primitive's first vertex is accepted no earlier than the edge after out_ready handshake.
REQ-027 clear = 1 at an edge, in any state: go to COLLECT, counter 0, out_valid 0; the vertex presented that edge is dropped; prim_id unchanged; clear has priority over both handshakes.
REQ-028 Output registers xmin..ymax and culled hold their last values outside HOLD.
REQ-029 With NUM_VERT = 1, xmin = xmax and ymin = ymax after rounding.

Reset
REQ-030 RST asserted: immediately state COLLECT, counter 0, accumulators 0, out_valid 0, in_ready 1 (while RST low after release), xmin/xmax/ymin/ymax 0, culled 0, prim_id 0.
REQ-031 RST asserted mid-primitive or in HOLD discards all partial and pending results; no result is emitted for it.

Verification (defaults, Q10.6)
REQ-032 Vertices x = 0x0A20, 0x1910, 0xAF00; y = 0x0280, 0x0530, 0x0140, out_ready = 1 -> out_valid 2 cycles after the 3rd accept; xmin 41, xmax 639, ymin 5, ymax 21, culled 0, prim_id 0.
REQ-033 x = 650.0, 660.0, 700.0 (0xA280, 0xA500, 0xAF00); y = 1.0, 2.0, 3.0 -> culled 1, xmin 639, xmax 639, ymin 1, ymax 3.
REQ-034 out_ready held low for 5 cycles in HOLD -> out_valid and all outputs stable, in_ready 0 throughout; handshake -> in_ready 1 next cycle, prim_id 1.
REQ-035 clear pulsed after 2 accepted vertices, then 3 vertices (x 0x0040, 0x0080, 0x00C0; y same) -> single result xmin 1, xmax 3, ymin 1, ymax 3; the earlier 2 vertices have no effect.
REQ-036 x = 0xFFFF as one vertex -> rounded value saturates at 1023 before clamping, then xmax 639; RST asserted in HOLD -> out_valid 0 and all outputs 0 immediately.
REQ-037 256 back-to-back primitives -> prim_id wraps from 255 to 0.
